// File: rtl/serial_slave_port_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_slave_port_pkg : state encodings and bus polarity constants
// Rev 1.0
// ---------------------------------------------------------------------------
package serial_slave_port_pkg;

  typedef logic [3:0] state_t;

  localparam state_t c_st_idle   = 4'd0;
  localparam state_t c_st_addr   = 4'd1;
  localparam state_t c_st_ignore = 4'd2;
  localparam state_t c_st_wdata  = 4'd3;
  localparam state_t c_st_write  = 4'd4;
  localparam state_t c_st_rreq   = 4'd5;
  localparam state_t c_st_rwait  = 4'd6;
  localparam state_t c_st_rstart = 4'd7;
  localparam state_t c_st_rdata  = 4'd8;

  localparam logic c_bus_util_active = 1'b0;
  localparam logic c_rw_write        = 1'b1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_slave_port_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_slave_port_if : serial bus side and parallel memory side of a slave
// Rev 1.0
// ---------------------------------------------------------------------------
interface serial_slave_port_if #(
  parameter int ADDRESS_WIDTH = 15,
  parameter int ID_WIDTH      = 3,
  parameter int DATA_WIDTH    = 8
);
  logic                              bus_util;
  logic                              rd_wrt;
  logic                              data_bus_in;
  logic                              bus_drive_low;
  logic                              arbiter_cmd_in;
  logic                              busy_out;
  logic [ADDRESS_WIDTH-ID_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]             mem_wdata;
  logic                              mem_we;
  logic                              mem_re;
  logic [DATA_WIDTH-1:0]             mem_rdata;
  logic                              mem_rvalid;
  logic                              timeout_err;

  modport slave (
    input  bus_util, rd_wrt, data_bus_in, arbiter_cmd_in, mem_rdata, mem_rvalid,
    output bus_drive_low, busy_out, mem_addr, mem_wdata, mem_we, mem_re, timeout_err
  );

  modport master (
    output bus_util, rd_wrt, data_bus_in, arbiter_cmd_in, mem_rdata, mem_rvalid,
    input  bus_drive_low, busy_out, mem_addr, mem_wdata, mem_we, mem_re, timeout_err
  );
endinterface
`default_nettype wire

// File: rtl/serial_slave_port_shifter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_shifter : MSB-first shift register with parallel load and bit counter
// Rev 1.0
// ---------------------------------------------------------------------------
module serial_shifter #(
  parameter int WIDTH     = 15,
  parameter int CNT_WIDTH = 4
) (
  input  wire logic                 clk,
  input  wire logic                 rstn,
  input  wire logic                 i_load,
  input  wire logic [WIDTH-1:0]     i_load_data,
  input  wire logic [CNT_WIDTH-1:0] i_load_count,
  input  wire logic                 i_shift,
  input  wire logic                 i_shift_in,
  output logic      [WIDTH-1:0]     o_data,
  output logic      [CNT_WIDTH-1:0] o_count,
  output logic                      o_last
);
  logic [WIDTH-1:0]     r_data;
  logic [CNT_WIDTH-1:0] r_count;

  // Load wins over shift; the counter saturates at zero instead of wrapping.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_data  <= '0;
      r_count <= '0;
    end else if (i_load) begin
      r_data  <= i_load_data;
      r_count <= i_load_count;
    end else if (i_shift) begin
      r_data <= {r_data[WIDTH-2:0], i_shift_in};
      if (r_count != '0) r_count <= r_count - 1'b1;
    end
  end

  assign o_data  = r_data;
  assign o_count = r_count;
  assign o_last  = (r_count == CNT_WIDTH'(1));
endmodule
`default_nettype wire

// File: rtl/serial_slave_port.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_slave_port : single-wire serial bus responder with a parallel memory port
// Rev 1.0
// ---------------------------------------------------------------------------
module serial_slave_port
  import serial_slave_port_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 15,
  parameter int ID_WIDTH      = 3,
  parameter int DATA_WIDTH    = 8,
  parameter int SELF_ID       = 3,
  parameter int TIMEOUT_LEN   = 6
) (
  input wire logic           clk,
  input wire logic           rstn,
  serial_slave_port_if.slave bus
);
  localparam int LOCAL_WIDTH = ADDRESS_WIDTH - ID_WIDTH;
  localparam int SR_WIDTH    = max_int(ADDRESS_WIDTH, DATA_WIDTH);
  localparam int CNT_WIDTH   = $clog2(SR_WIDTH + 1);

  localparam logic [ID_WIDTH-1:0]  c_self_id    = ID_WIDTH'(SELF_ID);
  localparam logic [CNT_WIDTH-1:0] c_cnt_addr   = CNT_WIDTH'(ADDRESS_WIDTH);
  localparam logic [CNT_WIDTH-1:0] c_cnt_data   = CNT_WIDTH'(DATA_WIDTH);
  localparam logic [CNT_WIDTH-1:0] c_cnt_id_chk = CNT_WIDTH'(ADDRESS_WIDTH - ID_WIDTH + 1);
  localparam logic [CNT_WIDTH-1:0] c_cnt_local  = CNT_WIDTH'(LOCAL_WIDTH);

  state_t                 r_state;
  state_t                 w_next_state;
  logic [SR_WIDTH-1:0]    w_sr_data;
  logic [SR_WIDTH-1:0]    w_sr_next;
  logic [SR_WIDTH-1:0]    w_sh_load_data;
  logic [CNT_WIDTH-1:0]   w_sh_count;
  logic [CNT_WIDTH-1:0]   w_sh_load_count;
  logic                   w_sh_last;
  logic                   w_sh_load;
  logic                   w_sh_shift;
  logic [LOCAL_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0]  r_mem_wdata;
  logic [TIMEOUT_LEN-1:0] r_wait_cnt;
  logic                   w_abort;
  logic                   w_start;
  logic                   w_drive;
  logic                   w_busy;
  logic                   w_we;
  logic                   w_re;
  logic                   w_tmo_err;

  serial_shifter #(
    .WIDTH     (SR_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_shifter (
    .clk          (clk),
    .rstn         (rstn),
    .i_load       (w_sh_load),
    .i_load_data  (w_sh_load_data),
    .i_load_count (w_sh_load_count),
    .i_shift      (w_sh_shift),
    .i_shift_in   (bus.data_bus_in),
    .o_data       (w_sr_data),
    .o_count      (w_sh_count),
    .o_last       (w_sh_last)
  );

  // Field value including the bit on the wire this cycle.
  assign w_sr_next = {w_sr_data[SR_WIDTH-2:0], bus.data_bus_in};
  assign w_abort   = (bus.bus_util != c_bus_util_active) || bus.arbiter_cmd_in;
  assign w_start   = (bus.bus_util == c_bus_util_active) && !bus.data_bus_in;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= c_st_idle;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (r_state != c_st_idle && w_abort) begin
      w_next_state = c_st_idle;
    end else begin
      case (r_state)
        c_st_idle:   if (w_start) w_next_state = c_st_addr;
        c_st_addr: begin
          if (w_sh_count == c_cnt_id_chk && w_sr_next[ID_WIDTH-1:0] != c_self_id)
            w_next_state = c_st_ignore;
          else if (w_sh_last) begin
            if (w_sr_next[ADDRESS_WIDTH-1 -: ID_WIDTH] != c_self_id)
              w_next_state = c_st_ignore;
            else if (bus.rd_wrt == c_rw_write)
              w_next_state = c_st_wdata;
            else
              w_next_state = c_st_rreq;
          end
        end
        c_st_ignore: w_next_state = c_st_ignore;
        c_st_wdata:  if (w_sh_last) w_next_state = c_st_write;
        c_st_write:  w_next_state = c_st_idle;
        c_st_rreq:   w_next_state = c_st_rwait;
        c_st_rwait: begin
          if (bus.mem_rvalid)     w_next_state = c_st_rstart;
          else if (&r_wait_cnt)   w_next_state = c_st_idle;
        end
        c_st_rstart: w_next_state = c_st_rdata;
        c_st_rdata:  if (w_sh_last) w_next_state = c_st_idle;
        default:     w_next_state = c_st_idle;
      endcase
    end
  end

  always_comb begin
    w_drive         = 1'b0;
    w_busy          = 1'b0;
    w_we            = 1'b0;
    w_re            = 1'b0;
    w_tmo_err       = 1'b0;
    w_sh_load       = 1'b0;
    w_sh_shift      = 1'b0;
    w_sh_load_data  = '0;
    w_sh_load_count = '0;
    case (r_state)
      c_st_idle: begin
        w_sh_load       = w_start;
        w_sh_load_count = c_cnt_addr;
      end
      c_st_addr: begin
        // Ownership is claimed only once the whole ID field has matched.
        w_busy          = (w_sh_count <= c_cnt_local);
        w_sh_shift      = 1'b1;
        w_sh_load       = w_sh_last;
        w_sh_load_count = c_cnt_data;
      end
      c_st_wdata: begin
        w_busy     = 1'b1;
        w_sh_shift = 1'b1;
      end
      c_st_write: begin
        w_busy = 1'b1;
        w_we   = !w_abort;
      end
      c_st_rreq: begin
        w_busy = 1'b1;
        w_re   = !w_abort;
      end
      c_st_rwait: begin
        w_busy          = 1'b1;
        w_sh_load       = bus.mem_rvalid;
        w_sh_load_data  = SR_WIDTH'(bus.mem_rdata) << (SR_WIDTH - DATA_WIDTH);
        w_sh_load_count = c_cnt_data;
        w_tmo_err       = !bus.mem_rvalid && (&r_wait_cnt) && !w_abort;
      end
      c_st_rstart: begin
        w_busy  = 1'b1;
        w_drive = 1'b1;
      end
      c_st_rdata: begin
        w_busy     = 1'b1;
        w_drive    = !w_sr_data[SR_WIDTH-1];
        w_sh_shift = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_wait_cnt  <= '0;
    end else begin
      if (r_state == c_st_addr && w_sh_last)  r_mem_addr  <= w_sr_next[LOCAL_WIDTH-1:0];
      if (r_state == c_st_wdata && w_sh_last) r_mem_wdata <= w_sr_next[DATA_WIDTH-1:0];
      if (r_state == c_st_rwait) r_wait_cnt <= r_wait_cnt + 1'b1;
      else                       r_wait_cnt <= '0;
    end
  end

  assign bus.bus_drive_low = w_drive;
  assign bus.busy_out      = w_busy;
  assign bus.mem_addr      = r_mem_addr;
  assign bus.mem_wdata     = r_mem_wdata;
  assign bus.mem_we        = w_we;
  assign bus.mem_re        = w_re;
  assign bus.timeout_err   = w_tmo_err;
endmodule
`default_nettype wire

// File: tb/tb_serial_slave_port.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_serial_slave_port : randomized frames against a timeline model of the slave
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_serial_slave_port;
  logic clk = 1'b0;
  logic rstn;
  logic m_low;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serial_slave_port_if #(.ADDRESS_WIDTH(15), .ID_WIDTH(3), .DATA_WIDTH(8)) bus ();

  serial_slave_port #(
    .ADDRESS_WIDTH(15), .ID_WIDTH(3), .DATA_WIDTH(8), .SELF_ID(3), .TIMEOUT_LEN(6)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // Open-drain wire: low if either side pulls.
  assign bus.data_bus_in = ~(m_low | bus.bus_drive_low);

  logic        o_drv  [0:127];
  logic        o_busy [0:127];
  logic        o_we   [0:127];
  logic        o_re   [0:127];
  logic        o_to   [0:127];
  logic [11:0] o_addr [0:127];
  logic [7:0]  o_wd   [0:127];

  task automatic idle_inputs();
    m_low              = 1'b0;
    bus.bus_util       = 1'b1;
    bus.rd_wrt         = 1'b0;
    bus.arbiter_cmd_in = 1'b0;
    bus.mem_rvalid     = 1'b0;
    bus.mem_rdata      = 8'h00;
  endtask

  task automatic frame_gap(input int n);
    idle_inputs();
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Plays one master frame cycle by cycle (t=0 is the start bit) and records the
  // slave outputs; a memory responder answers mem_re after lat clocks (0 = never).
  task automatic run_frame(input logic [2:0] id, input logic [11:0] la, input logic wr,
                           input logic [7:0] wd, input int lat, input logic [7:0] rd,
                           input int abort_t, input bit abort_arb, input int late_t,
                           input int ncyc);
    logic [14:0] addr;
    int re_t;
    addr = {id, la};
    re_t = -1;
    for (int t = 0; t < ncyc; t++) begin
      bus.bus_util       = !abort_arb && abort_t >= 0 && t >= abort_t;
      bus.arbiter_cmd_in = abort_arb && t == abort_t;
      bus.rd_wrt         = wr;
      if (bus.bus_util)         m_low = 1'b0;
      else if (t == 0)          m_low = 1'b1;
      else if (t <= 15)         m_low = ~addr[15-t];
      else if (wr && t <= 23)   m_low = ~wd[23-t];
      else                      m_low = 1'b0;
      bus.mem_rvalid = (re_t >= 0 && lat > 0 && t == re_t + lat) || t == late_t;
      bus.mem_rdata  = bus.mem_rvalid ? rd : 8'($urandom);
      @(negedge clk);
      o_drv[t]  = bus.bus_drive_low;
      o_busy[t] = bus.busy_out;
      o_we[t]   = bus.mem_we;
      o_re[t]   = bus.mem_re;
      o_to[t]   = bus.timeout_err;
      o_addr[t] = bus.mem_addr;
      o_wd[t]   = bus.mem_wdata;
      if (bus.mem_re && re_t < 0) re_t = t;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.bus_drive_low !== 1'b0) begin errors++; $display("FAIL reset_drive got %b exp 0", bus.bus_drive_low); end
    checks++; if (bus.busy_out !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy_out); end
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b exp 0", bus.mem_we); end
    checks++; if (bus.mem_re !== 1'b0) begin errors++; $display("FAIL reset_re got %b exp 0", bus.mem_re); end
    checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL reset_tmo got %b exp 0", bus.timeout_err); end
    checks++; if (bus.mem_addr !== 12'h000) begin errors++; $display("FAIL reset_addr got %h exp 000", bus.mem_addr); end
    checks++; if (bus.mem_wdata !== 8'h00) begin errors++; $display("FAIL reset_wdata got %h exp 00", bus.mem_wdata); end
    @(posedge clk);
    #1 rstn = 1'b1;
    frame_gap(2);
  endtask

  task automatic test_write();
    for (int k = 0; k < 5; k++) begin
      logic [11:0] la;
      logic [7:0]  wd;
      la = (k == 0) ? 12'd0 : 12'($urandom);
      wd = (k == 0) ? 8'd231 : 8'($urandom);
      run_frame(3'd3, la, 1'b1, wd, 0, 8'h00, -1, 1'b0, -1, 28);
      for (int t = 0; t < 28; t++) begin
        checks++; if (o_busy[t] !== (t >= 4 && t <= 24)) begin errors++; $display("FAIL write_busy t=%0d got %b exp %b", t, o_busy[t], (t >= 4 && t <= 24)); end
        checks++; if (o_we[t] !== (t == 24)) begin errors++; $display("FAIL write_we t=%0d got %b exp %b", t, o_we[t], (t == 24)); end
        checks++; if ({o_re[t], o_drv[t], o_to[t]} !== 3'b000) begin errors++; $display("FAIL write_quiet t=%0d got re/drv/to %b%b%b exp 000", t, o_re[t], o_drv[t], o_to[t]); end
      end
      checks++; if (o_addr[24] !== la) begin errors++; $display("FAIL write_addr got %h exp %h", o_addr[24], la); end
      checks++; if (o_wd[24] !== wd) begin errors++; $display("FAIL write_data got %h exp %h", o_wd[24], wd); end
      frame_gap(2);
    end
  endtask

  task automatic test_read();
    for (int k = 0; k < 5; k++) begin
      logic [11:0] la;
      logic [7:0]  rd;
      logic [8:0]  seq;
      int          lat;
      logic        exp_drv;
      la  = (k == 0) ? 12'd2564 : 12'($urandom);
      rd  = (k == 0) ? 8'd153 : 8'($urandom);
      lat = (k == 0) ? 2 : int'($urandom_range(1, 5));
      run_frame(3'd3, la, 1'b0, 8'h00, lat, rd, -1, 1'b0, -1, 28 + lat);
      for (int t = 0; t < 28 + lat; t++) begin
        if (t == 17 + lat)                        exp_drv = 1'b1;
        else if (t >= 18 + lat && t <= 25 + lat)  exp_drv = ~rd[25+lat-t];
        else                                      exp_drv = 1'b0;
        checks++; if (o_drv[t] !== exp_drv) begin errors++; $display("FAIL read_drive t=%0d got %b exp %b", t, o_drv[t], exp_drv); end
        checks++; if (o_busy[t] !== (t >= 4 && t <= 25 + lat)) begin errors++; $display("FAIL read_busy t=%0d got %b exp %b", t, o_busy[t], (t >= 4 && t <= 25 + lat)); end
        checks++; if (o_re[t] !== (t == 16)) begin errors++; $display("FAIL read_re t=%0d got %b exp %b", t, o_re[t], (t == 16)); end
        checks++; if ({o_we[t], o_to[t]} !== 2'b00) begin errors++; $display("FAIL read_quiet t=%0d got we/to %b%b exp 00", t, o_we[t], o_to[t]); end
      end
      checks++; if (o_addr[16] !== la) begin errors++; $display("FAIL read_addr got %h exp %h", o_addr[16], la); end
      if (k == 0) begin
        for (int i = 0; i < 9; i++) seq[8-i] = o_drv[19+i];
        checks++; if (seq !== 9'b101100110) begin errors++; $display("FAIL read_seq got %b exp 101100110", seq); end
      end
      frame_gap(2);
    end
  endtask

  task automatic test_id_mismatch();
    for (int k = 0; k < 4; k++) begin
      logic [2:0]  id;
      logic [11:0] la;
      logic        wr;
      id = (k == 0) ? 3'd4 : 3'((4 + $urandom_range(0, 6)) % 8);
      la = (k == 0) ? 12'd1500 : 12'($urandom);
      wr = (k == 0) ? 1'b1 : 1'($urandom);
      run_frame(id, la, wr, 8'($urandom), 1, 8'($urandom), -1, 1'b0, -1, 30);
      for (int t = 0; t < 30; t++) begin
        checks++; if ({o_busy[t], o_drv[t], o_we[t], o_re[t]} !== 4'b0000) begin errors++; $display("FAIL idmis_quiet id=%0d t=%0d got busy/drv/we/re %b%b%b%b exp 0000", id, t, o_busy[t], o_drv[t], o_we[t], o_re[t]); end
      end
      frame_gap(2);
      run_frame(3'd3, la, 1'b1, 8'h5A, 0, 8'h00, -1, 1'b0, -1, 27);
      checks++; if (o_we[24] !== 1'b1) begin errors++; $display("FAIL idmis_next_we got %b exp 1", o_we[24]); end
      checks++; if (o_wd[24] !== 8'h5A) begin errors++; $display("FAIL idmis_next_data got %h exp 5a", o_wd[24]); end
      frame_gap(2);
    end
  endtask

  task automatic test_abort();
    // Bus release at a random point of a write, including the strobe cycle.
    for (int k = 0; k < 4; k++) begin
      int ab;
      ab = (k == 0) ? 10 : (k == 1) ? 24 : int'($urandom_range(4, 24));
      run_frame(3'd3, 12'($urandom), 1'b1, 8'($urandom), 0, 8'h00, ab, 1'b0, -1, 28);
      for (int t = 0; t < 28; t++) begin
        checks++; if (o_busy[t] !== (t >= 4 && t <= ab)) begin errors++; $display("FAIL abort_busy ab=%0d t=%0d got %b exp %b", ab, t, o_busy[t], (t >= 4 && t <= ab)); end
        checks++; if ({o_we[t], o_re[t], o_drv[t]} !== 3'b000) begin errors++; $display("FAIL abort_quiet ab=%0d t=%0d got we/re/drv %b%b%b exp 000", ab, t, o_we[t], o_re[t], o_drv[t]); end
      end
      frame_gap(2);
    end
    // Arbiter abort on the write strobe cycle suppresses it.
    run_frame(3'd3, 12'h123, 1'b1, 8'hC3, 0, 8'h00, 24, 1'b1, -1, 28);
    checks++; if (o_we[24] !== 1'b0) begin errors++; $display("FAIL abort_arb_we got %b exp 0", o_we[24]); end
    checks++; if (o_busy[25] !== 1'b0) begin errors++; $display("FAIL abort_arb_idle got %b exp 0", o_busy[25]); end
    frame_gap(2);
    // Arbiter abort while the slave transmits read data.
    for (int k = 0; k < 3; k++) begin
      int lat;
      int ab;
      logic [7:0] rd;
      logic exp_drv;
      lat = int'($urandom_range(1, 4));
      ab  = 18 + lat + int'($urandom_range(0, 7));
      rd  = 8'($urandom);
      run_frame(3'd3, 12'($urandom), 1'b0, 8'h00, lat, rd, ab, 1'b1, -1, 30 + lat);
      for (int t = 0; t < 30 + lat; t++) begin
        if (t > ab)               exp_drv = 1'b0;
        else if (t == 17 + lat)   exp_drv = 1'b1;
        else if (t >= 18 + lat)   exp_drv = ~rd[25+lat-t];
        else                      exp_drv = 1'b0;
        checks++; if (o_drv[t] !== exp_drv) begin errors++; $display("FAIL abort_rd_drive ab=%0d t=%0d got %b exp %b", ab, t, o_drv[t], exp_drv); end
        checks++; if (o_busy[t] !== (t >= 4 && t <= ab)) begin errors++; $display("FAIL abort_rd_busy ab=%0d t=%0d got %b exp %b", ab, t, o_busy[t], (t >= 4 && t <= ab)); end
      end
      frame_gap(2);
    end
  endtask

  task automatic test_timeout();
    run_frame(3'd3, 12'($urandom), 1'b0, 8'h00, 0, 8'hA5, -1, 1'b0, 82, 86);
    for (int t = 0; t < 86; t++) begin
      checks++; if (o_to[t] !== (t == 80)) begin errors++; $display("FAIL tmo_pulse t=%0d got %b exp %b", t, o_to[t], (t == 80)); end
      checks++; if (o_busy[t] !== (t >= 4 && t <= 80)) begin errors++; $display("FAIL tmo_busy t=%0d got %b exp %b", t, o_busy[t], (t >= 4 && t <= 80)); end
      checks++; if ({o_drv[t], o_we[t]} !== 2'b00) begin errors++; $display("FAIL tmo_quiet t=%0d got drv/we %b%b exp 00", t, o_drv[t], o_we[t]); end
      checks++; if (o_re[t] !== (t == 16)) begin errors++; $display("FAIL tmo_re t=%0d got %b exp %b", t, o_re[t], (t == 16)); end
    end
    frame_gap(2);
  endtask

  task automatic test_back_to_back();
    logic [7:0] rd;
    logic [8:0] seq;
    rd = 8'($urandom);
    run_frame(3'd3, 12'h0F0, 1'b1, 8'h3C, 0, 8'h00, -1, 1'b0, -1, 25);
    checks++; if (o_we[24] !== 1'b1) begin errors++; $display("FAIL b2b_we got %b exp 1", o_we[24]); end
    run_frame(3'd3, 12'h777, 1'b0, 8'h00, 1, rd, -1, 1'b0, -1, 27);
    checks++; if (o_re[16] !== 1'b1) begin errors++; $display("FAIL b2b_re got %b exp 1", o_re[16]); end
    checks++; if (o_addr[16] !== 12'h777) begin errors++; $display("FAIL b2b_addr got %h exp 777", o_addr[16]); end
    for (int i = 0; i < 9; i++) seq[8-i] = o_drv[18+i];
    checks++; if (seq !== {1'b1, ~rd}) begin errors++; $display("FAIL b2b_seq got %b exp %b", seq, {1'b1, ~rd}); end
    run_frame(3'd3, 12'h001, 1'b1, 8'h81, 0, 8'h00, -1, 1'b0, -1, 26);
    checks++; if (o_we[24] !== 1'b1) begin errors++; $display("FAIL b2b_we2 got %b exp 1", o_we[24]); end
    checks++; if (o_wd[24] !== 8'h81) begin errors++; $display("FAIL b2b_data2 got %h exp 81", o_wd[24]); end
    frame_gap(2);
  endtask

  task automatic test_reset_mid();
    logic [7:0] rd;
    rd = {2'b00, 6'($urandom)};
    run_frame(3'd3, 12'($urandom), 1'b0, 8'h00, 1, rd, -1, 1'b0, -1, 20);
    #2;
    checks++; if (bus.bus_drive_low !== 1'b1) begin errors++; $display("FAIL rstmid_pre_drive got %b exp 1", bus.bus_drive_low); end
    rstn = 1'b0;
    #1;
    checks++; if (bus.bus_drive_low !== 1'b0) begin errors++; $display("FAIL rstmid_drive got %b exp 0", bus.bus_drive_low); end
    checks++; if ({bus.busy_out, bus.mem_we, bus.mem_re, bus.timeout_err} !== 4'b0000) begin errors++; $display("FAIL rstmid_outs got %b exp 0000", {bus.busy_out, bus.mem_we, bus.mem_re, bus.timeout_err}); end
    checks++; if ({bus.mem_addr, bus.mem_wdata} !== 20'h0) begin errors++; $display("FAIL rstmid_regs got %h exp 0", {bus.mem_addr, bus.mem_wdata}); end
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    frame_gap(2);
    run_frame(3'd3, 12'h2AB, 1'b1, 8'h42, 0, 8'h00, -1, 1'b0, -1, 27);
    checks++; if (o_we[24] !== 1'b1 || o_addr[24] !== 12'h2AB) begin errors++; $display("FAIL rstmid_after got we=%b addr=%h exp 1 2ab", o_we[24], o_addr[24]); end
    frame_gap(2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired got running exp finished");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0;
    idle_inputs();
    test_reset();
    test_write();
    test_read();
    test_id_mismatch();
    test_abort();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
